ss_diag_reducer: RTL and testbench

- Sits directly downstream of the systolic matrix-multiply stage.
- Consumes its burst of 40-bit diagonal sums: 3 values for a 2x2 job, 7 for a 4x4 job, on contiguous valid cycles with no stall capability.
- Reduces each burst to a summary record (length, total sum, maximum and its index) and hands the record to the next stage over a valid/ready handshake.
- Flags malformed bursts and bursts lost to backpressure.

---
 rtl/ss_diag_reducer.sv | 168 ++++++++++++++++
 tb/tb_ss_diag_reducer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ss_diag_reducer.sv
// Reduces each burst of diagonal sums from the systolic stage to a summary record.
// Optional min tracking: define SS_DIAG_REDUCER_MIN_EN to add out_min/out_min_idx.
module ss_diag_reducer #(
    parameter int DATA_W  = 40,
    parameter int MAX_LEN = 7,
    parameter int SUM_W   = 43
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_value,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 out_len,
    output logic [SUM_W-1:0]           out_sum,
    output logic [DATA_W-1:0]          out_max,
    output logic [$clog2(MAX_LEN)-1:0] out_max_idx,
    output logic                       out_err,
`ifdef SS_DIAG_REDUCER_MIN_EN
    output logic [DATA_W-1:0]          out_min,
    output logic [$clog2(MAX_LEN)-1:0] out_min_idx,
`endif
    output logic                       ovf
);

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam logic [3:0] POS_LIM = 4'(1 << IDX_W);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD, DROP} state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [SUM_W-1:0]      r_acc_sum;
    logic [DATA_W-1:0]     r_acc_max;
    logic [IDX_W-1:0]      r_acc_idx;
    logic                  r_out_valid;
    logic [3:0]            r_out_len;
    logic [SUM_W-1:0]      r_out_sum;
    logic [DATA_W-1:0]     r_out_max;
    logic [IDX_W-1:0]      r_out_max_idx;
    logic                  r_out_err;
    logic                  r_ovf;

    logic                  w_pos_ok;
    logic                  w_new_max;
    logic [3:0]            w_cnt_inc;

    // Only the first 2^IDX_W positions can be represented by the index field.
    assign w_pos_ok  = (r_cnt < POS_LIM);
    assign w_new_max = w_pos_ok && (in_value > r_acc_max);
    assign w_cnt_inc = (r_cnt == 4'd15) ? 4'd15 : r_cnt + 4'd1;

`ifdef SS_DIAG_REDUCER_MIN_EN
    logic [DATA_W-1:0]     r_acc_min;
    logic [IDX_W-1:0]      r_acc_min_idx;
    logic [DATA_W-1:0]     r_out_min;
    logic [IDX_W-1:0]      r_out_min_idx;
    logic                  w_new_min;

    assign w_new_min   = w_pos_ok && (in_value < r_acc_min);
    assign out_min     = r_out_min;
    assign out_min_idx = r_out_min_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_min     <= '0;
            r_acc_min_idx <= '0;
            r_out_min     <= '0;
            r_out_min_idx <= '0;
        end else begin
            if (in_valid && (r_state == IDLE || (r_state == HOLD && out_ready))) begin
                r_acc_min     <= in_value;
                r_acc_min_idx <= '0;
            end else if (in_valid && r_state == COLLECT && w_new_min) begin
                r_acc_min     <= in_value;
                r_acc_min_idx <= r_cnt[IDX_W-1:0];
            end
            if (!in_valid && r_state == COLLECT) begin
                r_out_min     <= r_acc_min;
                r_out_min_idx <= r_acc_min_idx;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_acc_sum     <= '0;
            r_acc_max     <= '0;
            r_acc_idx     <= '0;
            r_out_valid   <= 1'b0;
            r_out_len     <= '0;
            r_out_sum     <= '0;
            r_out_max     <= '0;
            r_out_max_idx <= '0;
            r_out_err     <= 1'b0;
            r_ovf         <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_cnt     <= 4'd1;
                        r_acc_sum <= SUM_W'(in_value);
                        r_acc_max <= in_value;
                        r_acc_idx <= '0;
                        r_state   <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (in_valid) begin
                        r_cnt     <= w_cnt_inc;
                        r_acc_sum <= r_acc_sum + SUM_W'(in_value);
                        if (w_new_max) begin
                            r_acc_max <= in_value;
                            r_acc_idx <= r_cnt[IDX_W-1:0];
                        end
                    end else begin
                        r_out_len     <= r_cnt;
                        r_out_sum     <= r_acc_sum;
                        r_out_max     <= r_acc_max;
                        r_out_max_idx <= r_acc_idx;
                        r_out_err     <= (r_cnt != 4'd3) && (r_cnt != 4'd7);
                        r_out_valid   <= 1'b1;
                        r_state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (in_valid) begin
                            r_cnt     <= 4'd1;
                            r_acc_sum <= SUM_W'(in_value);
                            r_acc_max <= in_value;
                            r_acc_idx <= '0;
                            r_state   <= COLLECT;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (in_valid) begin
                        r_ovf   <= 1'b1;
                        r_state <= DROP;
                    end
                end
                DROP: begin
                    // A retirement here never restarts collection; the rest of this burst is lost.
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                    if (!in_valid) begin
                        r_state <= (r_out_valid && !out_ready) ? HOLD : IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid   = r_out_valid;
    assign out_len     = r_out_len;
    assign out_sum     = r_out_sum;
    assign out_max     = r_out_max;
    assign out_max_idx = r_out_max_idx;
    assign out_err     = r_out_err;
    assign ovf         = r_ovf;

endmodule

// File: tb/tb_ss_diag_reducer.sv
// Self-checking bench for ss_diag_reducer: directed scenarios plus random bursts vs a reference model.
module tb_ss_diag_reducer;

    localparam int DATA_W = 40;
    localparam int SUM_W  = 43;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_value;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_len;
    logic [SUM_W-1:0]  out_sum;
    logic [DATA_W-1:0] out_max;
    logic [2:0]        out_max_idx;
    logic              out_err;
    logic              ovf;
`ifdef SS_DIAG_REDUCER_MIN_EN
    logic [DATA_W-1:0] out_min;
    logic [2:0]        out_min_idx;
`endif

    always #5 clk = ~clk;

    ss_diag_reducer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_value    (in_value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_len     (out_len),
        .out_sum     (out_sum),
        .out_max     (out_max),
        .out_max_idx (out_max_idx),
        .out_err     (out_err),
`ifdef SS_DIAG_REDUCER_MIN_EN
        .out_min     (out_min),
        .out_min_idx (out_min_idx),
`endif
        .ovf         (ovf)
    );

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] burst_q[$];
    logic [3:0]        e_len;
    logic [SUM_W-1:0]  e_sum;
    logic [DATA_W-1:0] e_max;
    logic [2:0]        e_idx;
    logic              e_err;
    logic [DATA_W-1:0] e_min;
    logic [2:0]        e_min_idx;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: summary of the whole queued burst, straight from the rules.
    task automatic model;
        int n;
        logic [63:0] total;
        n     = burst_q.size();
        total = 0;
        foreach (burst_q[i]) total += 64'(burst_q[i]);
        e_len     = (n > 15) ? 4'd15 : 4'(n);
        e_sum     = total[SUM_W-1:0];
        e_err     = !(n == 3 || n == 7);
        e_max     = burst_q[0];
        e_idx     = 3'd0;
        e_min     = burst_q[0];
        e_min_idx = 3'd0;
        for (int i = 1; i < n && i < 8; i++) begin
            if (burst_q[i] > e_max) begin e_max = burst_q[i]; e_idx = 3'(i); end
            if (burst_q[i] < e_min) begin e_min = burst_q[i]; e_min_idx = 3'(i); end
        end
    endtask

    task automatic drive_burst;
        foreach (burst_q[i]) begin
            in_valid = 1'b1;
            in_value = burst_q[i];
            tick();
        end
        in_valid = 1'b0;
        in_value = '0;
        tick();
    endtask

    task automatic check_rec(input string tag, input logic [3:0] len, input logic [SUM_W-1:0] sum,
                             input logic [DATA_W-1:0] mx, input logic [2:0] idx, input logic err);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_len"}, 64'(out_len), 64'(len));
        chk({tag, "_sum"}, 64'(out_sum), 64'(sum));
        chk({tag, "_max"}, 64'(out_max), 64'(mx));
        chk({tag, "_idx"}, 64'(out_max_idx), 64'(idx));
        chk({tag, "_err"}, 64'(out_err), 64'(err));
    endtask

    initial begin
        logic [63:0] rnd;
        int          n;
        int          hold_cycles;
        int          stray;

        rst = 1'b1; in_valid = 1'b0; in_value = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_len", 64'(out_len), 64'd0);
        chk("rst_sum", 64'(out_sum), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);

        out_ready = 1'b1;
        burst_q = '{40'd5, 40'd9, 40'd2};
        drive_burst();
        check_rec("b3", 4'd3, 43'd16, 40'd9, 3'd1, 1'b0);
        $display("txn b3 len=%0d sum=%0d max=%0d idx=%0d err=%0d", out_len, out_sum, out_max, out_max_idx, out_err);
        tick();
        chk("b3_retire", 64'(out_valid), 64'd0);
        chk("b3_hold_sum", 64'(out_sum), 64'd16);

        burst_q = '{40'd4, 40'd4, 40'd1, 40'd4, 40'd0, 40'd3, 40'd2};
        drive_burst();
        check_rec("b7tie", 4'd7, 43'd18, 40'd4, 3'd0, 1'b0);
        $display("txn b7tie len=%0d sum=%0d max=%0d idx=%0d", out_len, out_sum, out_max, out_max_idx);
        tick();

        burst_q = {};
        for (int i = 0; i < 7; i++) burst_q.push_back({DATA_W{1'b1}});
        drive_burst();
        check_rec("b7full", 4'd7, 43'h6FF_FFFF_FFF9, {DATA_W{1'b1}}, 3'd0, 1'b0);
        $display("txn b7full sum=%0h", out_sum);
        tick();

        burst_q = '{40'd1, 40'd2, 40'd3, 40'd4, 40'd5};
        drive_burst();
        check_rec("b5", 4'd5, 43'd15, 40'd5, 3'd4, 1'b1);
        $display("txn b5 len=%0d err=%0d", out_len, out_err);
        tick();

        // Positions 8 and up add to sum and count only.
        burst_q = '{40'd3, 40'd3, 40'd3, 40'd3, 40'd3, 40'd3, 40'd3, 40'd3, 40'd50, 40'd60};
        drive_burst();
        check_rec("b10", 4'd10, 43'd134, 40'd3, 3'd0, 1'b1);
        $display("txn b10 len=%0d sum=%0d max=%0d", out_len, out_sum, out_max);
        tick();

        burst_q = {};
        for (int i = 0; i < 17; i++) burst_q.push_back(40'd1);
        drive_burst();
        check_rec("b17", 4'd15, 43'd17, 40'd1, 3'd0, 1'b1);
        $display("txn b17 len=%0d sum=%0d", out_len, out_sum);
        tick();

        // Back-to-back: the next burst starts on the handshake cycle.
        burst_q = '{40'd1, 40'd2, 40'd3};
        drive_burst();
        check_rec("bb_a", 4'd3, 43'd6, 40'd3, 3'd2, 1'b0);
        burst_q = '{40'd4, 40'd5, 40'd6, 40'd7, 40'd8, 40'd9, 40'd10};
        drive_burst();
        check_rec("bb_b", 4'd7, 43'd49, 40'd10, 3'd6, 1'b0);
        $display("txn back2back sum=%0d", out_sum);
        tick();
        chk("bb_retire", 64'(out_valid), 64'd0);

        // Backpressure: the second burst is dropped while the first record is held.
        out_ready = 1'b0;
        burst_q = '{40'd1, 40'd2, 40'd3};
        drive_burst();
        check_rec("bp_first", 4'd3, 43'd6, 40'd3, 3'd2, 1'b0);
        chk("bp_ovf_pre", 64'(ovf), 64'd0);
        burst_q = '{40'd7, 40'd8, 40'd9};
        drive_burst();
        chk("bp_ovf", 64'(ovf), 64'd1);
        check_rec("bp_held", 4'd3, 43'd6, 40'd3, 3'd2, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("bp_retire", 64'(out_valid), 64'd0);
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) stray++;
        end
        chk("bp_no_second", 64'(stray), 64'd0);
        chk("bp_ovf_sticky", 64'(ovf), 64'd1);
        $display("txn backpressure ovf=%0d stray=%0d", ovf, stray);

        // Reset in the middle of a collection.
        in_valid = 1'b1; in_value = 40'd11; tick();
        in_value = 40'd12; tick();
        rst = 1'b1; in_valid = 1'b0; in_value = '0;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_ovf", 64'(ovf), 64'd0);
        chk("mid_rst_len", 64'(out_len), 64'd0);
        tick();
        chk("mid_rst_stale", 64'(out_valid), 64'd0);
        burst_q = '{40'd10, 40'd20, 40'd30};
        drive_burst();
        check_rec("post_rst", 4'd3, 43'd60, 40'd30, 3'd2, 1'b0);
        chk("post_rst_ovf", 64'(ovf), 64'd0);
        $display("txn post_rst len=%0d sum=%0d ovf=%0d", out_len, out_sum, ovf);
        tick();

        // Random bursts with random downstream stall before acceptance.
        for (int t = 0; t < 30; t++) begin
            n = $urandom_range(1, 18);
            burst_q = {};
            for (int i = 0; i < n; i++) begin
                rnd = {$urandom(), $urandom()};
                if ($urandom_range(0, 1) == 0) burst_q.push_back(DATA_W'($urandom_range(0, 5)));
                else burst_q.push_back(rnd[DATA_W-1:0]);
            end
            model();
            out_ready = 1'($urandom_range(0, 1));
            drive_burst();
            out_ready = 1'b0;
            check_rec("rnd", e_len, e_sum, e_max, e_idx, e_err);
`ifdef SS_DIAG_REDUCER_MIN_EN
            chk("rnd_min", 64'(out_min), 64'(e_min));
            chk("rnd_min_idx", 64'(out_min_idx), 64'(e_min_idx));
`endif
            $display("txn rnd%0d n=%0d len=%0d sum=%0h max=%0h idx=%0d err=%0d",
                     t, n, out_len, out_sum, out_max, out_max_idx, out_err);
            hold_cycles = $urandom_range(0, 3);
            for (int k = 0; k < hold_cycles; k++) begin
                tick();
                chk("rnd_hold_valid", 64'(out_valid), 64'd1);
                chk("rnd_hold_sum", 64'(out_sum), 64'(e_sum));
            end
            out_ready = 1'b1;
            tick();
            chk("rnd_retire", 64'(out_valid), 64'd0);
            chk("rnd_ovf", 64'(ovf), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
